// File: rtl/f_pc_seq_pkg.sv
// Shared constants and state encoding for the fetch-stage PC sequencer.
package f_pc_seq_pkg;

    localparam logic [31:0] INITIAL_ADDR = 32'h0000_3000;
    localparam logic [31:0] TRAPPED_ADDR = 32'h0000_4180;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } seqState_t;

    // Sequential fetch address; the 32-bit sum wraps naturally.
    function automatic logic [31:0] seqNext(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/f_pc_seq_if.sv
// Bundle of the sequencer's request inputs and F_PC-facing outputs.
interface f_pc_seq_if;

    logic [31:0] pc;
    logic        stall;
    logic        fetch_ready;
    logic        br_req;
    logic [31:0] br_target;
    logic        eret_req;
    logic [31:0] epc;
    logic        trap_req;
    logic [31:0] npc;
    logic        pc_en;
    logic        trap_out;
    logic        f_flush;
    logic        busy;

    modport master (
        output pc, stall, fetch_ready, br_req, br_target, eret_req, epc, trap_req,
        input  npc, pc_en, trap_out, f_flush, busy
    );

    modport slave (
        input  pc, stall, fetch_ready, br_req, br_target, eret_req, epc, trap_req,
        output npc, pc_en, trap_out, f_flush, busy
    );

endinterface

// File: rtl/f_pc_pend.sv
// One pending-redirect slot: a valid flag plus the target it will replay.
module f_pc_pend (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_set,
    input  logic        i_clear,
    input  logic [31:0] i_target,
    output logic        o_valid,
    output logic [31:0] o_target
);

    logic        r_valid;
    logic [31:0] r_target;

    // A set always rewrites the target so the newest request wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid  <= 1'b0;
            r_target <= 32'd0;
        end else if (i_set) begin
            r_valid  <= 1'b1;
            r_target <= i_target;
        end else if (i_clear) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_target = r_target;

endmodule

// File: rtl/f_pc_seq.sv
// Fetch-stage PC sequencer: picks trap, ERET, branch or PC+4 for F_PC.
module f_pc_seq
    import f_pc_seq_pkg::*;
#(
    parameter logic [31:0] INIT_ADDR   = INITIAL_ADDR,
    parameter logic [31:0] TRAP_ADDR   = TRAPPED_ADDR,
    parameter int          BOOT_CYCLES = 2
) (
    input logic      clk,
    input logic      reset,
    f_pc_seq_if.slave bus
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    seqState_t   r_state;
    logic [3:0]  r_count;

    logic        w_active;
    logic        w_adv;
    logic        w_trap;
    logic        w_brPend;
    logic [31:0] w_brTgtReg;
    logic        w_erPend;
    logic [31:0] w_erTgtReg;
    logic        w_brEff;
    logic        w_erEff;
    logic [31:0] w_brTgt;
    logic [31:0] w_erTgt;
    logic        w_brSet;
    logic        w_erSet;
    logic        w_slotClear;

    assign w_active = (r_state != BOOT);
    assign w_adv    = bus.fetch_ready & ~bus.stall;
    assign w_trap   = w_active & bus.trap_req;

    assign w_brEff  = w_active & (bus.br_req | w_brPend);
    assign w_erEff  = w_active & (bus.eret_req | w_erPend);
    assign w_brTgt  = bus.br_req   ? bus.br_target : w_brTgtReg;
    assign w_erTgt  = bus.eret_req ? bus.epc       : w_erTgtReg;

    // Latch only requests that cannot be taken now; any adv edge either takes
    // the redirect or (branch under an ERET) drops it, and a trap drops both.
    assign w_brSet     = w_active & bus.br_req   & ~w_trap & ~w_adv;
    assign w_erSet     = w_active & bus.eret_req & ~w_trap & ~w_adv;
    assign w_slotClear = w_active & (w_trap | w_adv);

    f_pc_pend u_brSlot (
        .clk      (clk),
        .reset    (reset),
        .i_set    (w_brSet),
        .i_clear  (w_slotClear),
        .i_target (bus.br_target),
        .o_valid  (w_brPend),
        .o_target (w_brTgtReg)
    );

    f_pc_pend u_erSlot (
        .clk      (clk),
        .reset    (reset),
        .i_set    (w_erSet),
        .i_clear  (w_slotClear),
        .i_target (bus.epc),
        .o_valid  (w_erPend),
        .o_target (w_erTgtReg)
    );

    // Boot countdown, then RUN/PEND depending on whether a redirect is waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BOOT;
            r_count <= 4'd0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_count <= r_count + 4'd1;
                    if (r_count == BOOT_LAST) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!w_trap && (w_erEff || w_brEff) && !w_adv) begin
                        r_state <= PEND;
                    end
                end
                PEND: begin
                    if (w_trap || w_adv) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    // Next-PC selection by priority; during a trap F_PC takes TRAP_ADDR itself.
    always_comb begin
        bus.npc      = INIT_ADDR;
        bus.pc_en    = 1'b0;
        bus.trap_out = 1'b0;
        bus.f_flush  = 1'b0;
        bus.busy     = 1'b1;
        if (w_active) begin
            bus.busy     = (r_state == PEND);
            bus.trap_out = w_trap;
            if (w_trap) begin
                bus.npc     = TRAP_ADDR;
                bus.f_flush = 1'b1;
            end else if (w_erEff && w_adv) begin
                bus.npc     = w_erTgt;
                bus.pc_en   = 1'b1;
                bus.f_flush = 1'b1;
            end else if (w_brEff && w_adv) begin
                bus.npc     = w_brTgt;
                bus.pc_en   = 1'b1;
            end else begin
                bus.npc     = seqNext(bus.pc);
                bus.pc_en   = w_adv;
            end
        end
    end

endmodule
